// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receiver and decoder.
// PS2_WHEEL_EN selects 4-byte IntelliMouse packets instead of 3-byte packets.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    // Byte 0 fields kept for decode; bit 3 is a sync marker only.
    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic [2:0] btn;
    } ps2_hdr_t;

    localparam int unsigned DIR_RIGHT = 0;
    localparam int unsigned DIR_LEFT  = 1;
    localparam int unsigned DIR_UP    = 2;
    localparam int unsigned DIR_DOWN  = 3;
    localparam int unsigned DIR_CLICK = 4;

`ifdef PS2_WHEEL_EN
    localparam int unsigned PKT_BYTES = 4;
`else
    localparam int unsigned PKT_BYTES = 3;
`endif
    localparam int unsigned IDX_W = 2;

    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned timeout_us);
        return (clk_hz / 1_000_000) * timeout_us;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, glitch filter, 11-bit frame receiver and inactivity timeout.
// byte_valid_c / frame_err_c are single-cycle strobes valid in the sampling cycle.
module ps2_frame_rx
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 100_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic       byte_valid_c,
    output logic [7:0] byte_data,
    output logic       frame_err_c
);

    localparam int unsigned FW = $clog2(FILT_LEN);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    // Bit 0 is the clock line, bit 1 the data line.
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] flt_cnt [2];
    logic          clk_prev;
    logic          strobe, sdata, timeout_hit;

    frame_state_e  state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '1;
            sync2    <= '1;
            filt     <= '1;
            clk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            sync1    <= {ps2_data, ps2_clk};
            sync2    <= sync1;
            clk_prev <= filt[0];
            // A filtered line flips only after FILT_LEN consecutive differing samples.
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FW'(FILT_LEN - 1)) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FW'(1);
                end
            end
        end
    end

    assign strobe      = clk_prev & ~filt[0];
    assign sdata       = filt[1];
    assign timeout_hit = (to_cnt == CW'(TIMEOUT_CYC)) &&
                         ((state_q != ST_IDLE) || pkt_busy) && !strobe;
    assign byte_data   = shift_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_valid_c = 1'b0;
        frame_err_c  = 1'b0;
        if (strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sdata) state_d = ST_DATA;
                    else        frame_err_c = 1'b1;
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if ((^shift_q ^ parity_q) && sdata) byte_valid_c = 1'b1;
                    else                                frame_err_c  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d     = ST_IDLE;
            frame_err_c = 1'b1;
        end
    end

    // Shift register, parity capture and saturating inactivity counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            to_cnt   <= '0;
        end else begin
            if (strobe) begin
                to_cnt <= '0;
            end else if (to_cnt != CW'(TIMEOUT_CYC)) begin
                to_cnt <= to_cnt + CW'(1);
            end
            if (strobe) begin
                case (state_q)
                    ST_IDLE: bit_cnt <= '0;
                    ST_DATA: begin
                        shift_q <= {sdata, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: parity_q <= sdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse packet assembler and decoder on top of ps2_frame_rx.
// Define PS2_WHEEL_EN for 4-byte wheel packets and the wheel output.
module ps2_mouse_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FILT_LEN   = 4,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned DEAD_ZONE  = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       pkt_valid,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic [4:0] dir,
    output logic       frame_err
`ifdef PS2_WHEEL_EN
    ,
    output logic [3:0] wheel
`endif
);

    localparam int unsigned TIMEOUT_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);

    logic             byte_valid_c, frame_err_c;
    logic [7:0]       byte_data;
    logic [IDX_W-1:0] idx;
    ps2_hdr_t         hdr_q;
    logic [7:0]       b1_q;
`ifdef PS2_WHEEL_EN
    logic [7:0]       b2_q;
`endif
    logic             byte0_bad, last_byte;
    logic [8:0]       dx_d, dy_d;
    logic [4:0]       dir_d;
    logic signed [9:0] dx_s, dy_s, dz_pos, dz_neg;

    ps2_frame_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .pkt_busy     (idx != '0),
        .byte_valid_c (byte_valid_c),
        .byte_data    (byte_data),
        .frame_err_c  (frame_err_c)
    );

    // Decode of the packet completed by the current byte; compared at 10 bits so -256 holds.
    always_comb begin
        byte0_bad = byte_valid_c && (idx == '0) && !byte_data[3];
        last_byte = byte_valid_c && (idx == IDX_W'(PKT_BYTES - 1));
        dx_d      = {hdr_q.x_sign, b1_q};
`ifdef PS2_WHEEL_EN
        dy_d      = {hdr_q.y_sign, b2_q};
`else
        dy_d      = {hdr_q.y_sign, byte_data};
`endif
        dx_s      = {dx_d[8], dx_d};
        dy_s      = {dy_d[8], dy_d};
        dz_pos    = 10'(DEAD_ZONE);
        dz_neg    = -dz_pos;
        dir_d     = '0;
        if (hdr_q.x_ovf) begin
            dir_d[DIR_RIGHT] = ~dx_d[8];
            dir_d[DIR_LEFT]  = dx_d[8];
        end else begin
            dir_d[DIR_RIGHT] = dx_s > dz_pos;
            dir_d[DIR_LEFT]  = dx_s < dz_neg;
        end
        if (hdr_q.y_ovf) begin
            dir_d[DIR_UP]   = ~dy_d[8];
            dir_d[DIR_DOWN] = dy_d[8];
        end else begin
            dir_d[DIR_UP]   = dy_s > dz_pos;
            dir_d[DIR_DOWN] = dy_s < dz_neg;
        end
        dir_d[DIR_CLICK] = hdr_q.btn[0] | hdr_q.btn[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            hdr_q     <= '0;
            b1_q      <= '0;
`ifdef PS2_WHEEL_EN
            b2_q      <= '0;
            wheel     <= '0;
`endif
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            buttons   <= '0;
            dx        <= '0;
            dy        <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            dir       <= '0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= frame_err_c | byte0_bad;
            if (frame_err_c || byte0_bad) begin
                idx <= '0;
            end else if (last_byte) begin
                idx       <= '0;
                pkt_valid <= 1'b1;
                buttons   <= hdr_q.btn;
                dx        <= dx_d;
                dy        <= dy_d;
                x_ovf     <= hdr_q.x_ovf;
                y_ovf     <= hdr_q.y_ovf;
                dir       <= dir_d;
`ifdef PS2_WHEEL_EN
                wheel     <= byte_data[3:0];
`endif
            end else if (byte_valid_c) begin
                if (idx == '0)              hdr_q <= ps2_hdr_t'({byte_data[7:4], byte_data[2:0]});
                else if (idx == IDX_W'(1))  b1_q  <= byte_data;
`ifdef PS2_WHEEL_EN
                else                        b2_q  <= byte_data;
`endif
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Directed bench for ps2_mouse_decoder: bit-banged PS/2 frames, hand-computed expectations.
`timescale 1ns/1ps
module tb_ps2_mouse_decoder;

    localparam int HALF = 10;
    localparam int GAP  = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       pkt_valid, frame_err, x_ovf, y_ovf;
    logic [2:0] buttons;
    logic [8:0] dx, dy;
    logic [4:0] dir;
`ifdef PS2_WHEEL_EN
    logic [3:0] wheel;
`endif

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int fe_cnt = 0;
    int pv0, fe0;

    ps2_mouse_decoder #(
        .CLK_HZ     (1_000_000),
        .FILT_LEN   (4),
        .TIMEOUT_US (200),
        .DEAD_ZONE  (0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .pkt_valid (pkt_valid),
        .buttons   (buttons),
        .dx        (dx),
        .dy        (dy),
        .x_ovf     (x_ovf),
        .y_ovf     (y_ovf),
        .dir       (dir),
`ifdef PS2_WHEEL_EN
        .wheel     (wheel),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters: a pulse held two cycles counts twice.
    always @(negedge clk) begin
        if (pkt_valid) pv_cnt <= pv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        wait_clk(4);
        if (glitch) begin
            ps2_clk = 1'b0;
            wait_clk(1);
            ps2_clk = 1'b1;
            wait_clk(5);
        end else begin
            wait_clk(6);
        end
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic glitch);
        logic par;
        par = ~(^d) ^ bad_par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(par, glitch);
        send_bit(1'b1, glitch);
        ps2_data = 1'b1;
        wait_clk(GAP);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic glitch);
        send_byte(b0, 1'b0, glitch);
        send_byte(b1, 1'b0, glitch);
        send_byte(b2, 1'b0, glitch);
    endtask

    task automatic mark();
        pv0 = pv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        wait_clk(5);
        check("rst_pkt_valid", 32'(pkt_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_dx", 32'(dx), 32'h0);
        check("rst_dy", 32'(dy), 32'h0);
        check("rst_buttons", 32'(buttons), 32'h0);
        check("rst_dir", 32'(dir), 32'h0);
        check("rst_ovf", 32'({x_ovf, y_ovf}), 32'h0);
        reset_n = 1'b1;
        wait_clk(20);

        // 0x09,0x05,0xFB: left button, dx=+5, dy={0,FB}=+251
        mark();
        send_pkt(8'h09, 8'h05, 8'hFB, 1'b0);
        check("p1_pv", 32'(pv_cnt - pv0), 32'd1);
        check("p1_fe", 32'(fe_cnt - fe0), 32'd0);
        check("p1_dx", 32'(dx), 32'h005);
        check("p1_dy", 32'(dy), 32'h0FB);
        check("p1_buttons", 32'(buttons), 32'h1);
        check("p1_dir", 32'(dir), 32'b10101);

        // 0x38,0x00,0x00: both signs set, -256 on each axis
        mark();
        send_pkt(8'h38, 8'h00, 8'h00, 1'b0);
        check("p2_pv", 32'(pv_cnt - pv0), 32'd1);
        check("p2_dx", 32'(dx), 32'h100);
        check("p2_dy", 32'(dy), 32'h100);
        check("p2_buttons", 32'(buttons), 32'h0);
        check("p2_dir", 32'(dir), 32'b01010);

        // 0xC8,0x00,0x00: overflow on both axes, positive signs
        mark();
        send_pkt(8'hC8, 8'h00, 8'h00, 1'b0);
        check("ovf_pv", 32'(pv_cnt - pv0), 32'd1);
        check("ovf_flags", 32'({x_ovf, y_ovf}), 32'b11);
        check("ovf_dir", 32'(dir), 32'b00101);

        // Bad parity on byte 1, then a clean packet
        mark();
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        check("par_fe", 32'(fe_cnt - fe0), 32'd1);
        check("par_pv", 32'(pv_cnt - pv0), 32'd0);
        send_pkt(8'h0B, 8'h00, 8'h01, 1'b0);
        check("par_next_pv", 32'(pv_cnt - pv0), 32'd1);
        check("par_next_dx", 32'(dx), 32'h000);
        check("par_next_dy", 32'(dy), 32'h001);
        check("par_next_buttons", 32'(buttons), 32'h3);
        check("par_next_dir", 32'(dir), 32'b10100);

        // Byte 0 without sync bit, then a valid packet
        mark();
        send_byte(8'h00, 1'b0, 1'b0);
        send_pkt(8'h38, 8'h00, 8'h00, 1'b0);
        check("sync_fe", 32'(fe_cnt - fe0), 32'd1);
        check("sync_pv", 32'(pv_cnt - pv0), 32'd1);
        check("sync_dx", 32'(dx), 32'h100);

        // Two bytes then idle past the timeout
        mark();
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        wait_clk(400);
        check("to_fe", 32'(fe_cnt - fe0), 32'd1);
        check("to_pv", 32'(pv_cnt - pv0), 32'd0);
        send_pkt(8'h09, 8'h05, 8'hFB, 1'b0);
        check("to_next_pv", 32'(pv_cnt - pv0), 32'd1);
        check("to_next_fe", 32'(fe_cnt - fe0), 32'd1);
        check("to_next_dx", 32'(dx), 32'h005);
        check("to_next_dy", 32'(dy), 32'h0FB);

        // One-cycle glitches on ps2_clk during every bit
        mark();
        send_pkt(8'h0B, 8'h00, 8'h01, 1'b1);
        check("gl_pv", 32'(pv_cnt - pv0), 32'd1);
        check("gl_fe", 32'(fe_cnt - fe0), 32'd0);
        check("gl_dy", 32'(dy), 32'h001);
        check("gl_dir", 32'(dir), 32'b10100);

        // Reset in the middle of the second frame
        send_pkt(8'h09, 8'h05, 8'hFB, 1'b0);
        mark();
        send_byte(8'h09, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        reset_n = 1'b0;
        wait_clk(3);
        check("mid_rst_dx", 32'(dx), 32'h0);
        check("mid_rst_dy", 32'(dy), 32'h0);
        check("mid_rst_dir", 32'(dir), 32'h0);
        check("mid_rst_buttons", 32'(buttons), 32'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset_n  = 1'b1;
        wait_clk(300);
        check("mid_rst_pv", 32'(pv_cnt - pv0), 32'd0);
        check("mid_rst_fe", 32'(fe_cnt - fe0), 32'd0);
        send_pkt(8'h38, 8'h00, 8'h00, 1'b0);
        check("post_rst_pv", 32'(pv_cnt - pv0), 32'd1);
        check("post_rst_dx", 32'(dx), 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
